// File: rtl/dco_tune_sd.sv
// Sigma-delta dither of a fractional DCO tuning word onto the integer capacitor-array word.
// First-order accumulator (ORDER=1) or MASH 1-1 (ORDER=2); the output is clamped to 0..MAX.
module dco_tune_sd #(
  parameter int unsigned MAX    = 25,
  parameter int unsigned FRAC_W = 5,
  parameter int unsigned ORDER  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tune_valid,
  input  logic [FRAC_W+4:0] tune_word,
  output logic              tune_ready,
  output logic [4:0]        word,
  output logic              word_valid,
  output logic              sat
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_t;

  state_t            state_q, state_d;
  logic              live_q;
  logic [4:0]        int_q;
  logic [FRAC_W-1:0] frac_q, acc1_q, acc2_q;
  logic [FRAC_W-1:0] acc1_nxt, acc2_nxt;
  logic              c1, c2, c2d_q;
  logic [4:0]        word_q, word_nxt;
  logic              sat_q, sat_nxt;
  logic signed [6:0] raw;
  logic              accept, step;

  // live_q keeps tune_ready low after reset until the first enabled clock edge.
  assign tune_ready = live_q && en && (state_q != StHold);
  assign accept     = tune_valid && tune_ready;
  // A RUN update only happens on edges where en is still high.
  assign step       = (state_q == StRun) && en;
  assign word       = word_q;
  assign sat        = sat_q;
  assign word_valid = (state_q != StIdle);

  // Accumulator stages; the second stage integrates the first stage's new value.
  assign {c1, acc1_nxt} = {1'b0, acc1_q} + {1'b0, frac_q};
  assign {c2, acc2_nxt} = {1'b0, acc2_q} + {1'b0, acc1_nxt};

  // Raw dithered value and clamp to the legal array range.
  always_comb begin
    raw = 7'(int_q) + 7'(c1);
    if (ORDER == 2) begin
      raw = raw + 7'(c2) - 7'(c2d_q);
    end
    word_nxt = raw[4:0];
    sat_nxt  = 1'b0;
    if (raw < 0) begin
      word_nxt = 5'd0;
      sat_nxt  = 1'b1;
    end else if (raw > $signed(7'(MAX))) begin
      word_nxt = 5'(MAX);
      sat_nxt  = 1'b1;
    end
  end

  // Next-state logic for IDLE/RUN/HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (!en)    state_d = StHold;
      StHold:  if (en)     state_d = StRun;
      default:             state_d = StIdle;
    endcase
  end

  // State, tuning registers, accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      c2d_q   <= 1'b0;
      word_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (en) begin
        live_q <= 1'b1;
      end
      // The update on an accept edge still uses the old int/frac; new values apply next edge.
      if (accept) begin
        int_q  <= tune_word[FRAC_W+4:FRAC_W];
        frac_q <= tune_word[FRAC_W-1:0];
      end
      if (step) begin
        acc1_q <= acc1_nxt;
        acc2_q <= acc2_nxt;
        c2d_q  <= c2;
        word_q <= word_nxt;
        sat_q  <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dco_tune_sd.sv
// Directed bench for dco_tune_sd: one ORDER=1 and one ORDER=2 instance on shared stimulus.
module tb_dco_tune_sd;

  logic       clk = 1'b0;
  logic       rst, en, tune_valid;
  logic [9:0] tune_word;
  logic       rdy1, wv1, sat1, rdy2, wv2, sat2;
  logic [4:0] word1, word2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dco_tune_sd #(.MAX(25), .FRAC_W(5), .ORDER(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .tune_valid(tune_valid), .tune_word(tune_word),
    .tune_ready(rdy1), .word(word1), .word_valid(wv1), .sat(sat1)
  );

  dco_tune_sd #(.MAX(25), .FRAC_W(5), .ORDER(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .tune_valid(tune_valid), .tune_word(tune_word),
    .tune_ready(rdy2), .word(word2), .word_valid(wv2), .sat(sat2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in IDLE with tune_ready high.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tune_valid = 1'b0; tune_word = '0;
    tick();
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
  endtask

  task automatic accept(input int i, input int f);
    tune_valid = 1'b1;
    tune_word  = {i[4:0], f[4:0]};
    tick();
    tune_valid = 1'b0;
  endtask

  int ones, sats, bad, s_prev, s_now, c1, c2, c2_prev, raw, exp_w, exp_s;

  initial begin
    // Reset state
    rst = 1'b1; en = 1'b0; tune_valid = 1'b0; tune_word = '0;
    tick();
    check("rst_word", word1, 0);
    check("rst_valid", wv1, 0);
    check("rst_ready", rdy1, 0);
    check("rst_sat", sat1, 0);
    rst = 1'b0; en = 1'b1;
    #1;
    check("ready_before_edge", rdy1, 0);
    tick();
    check("ready_after_edge", rdy1, 1);
    check("idle_valid", wv1, 0);

    // First-order, int=10 frac=8: 11 on every 4th update
    accept(10, 8);
    check("accept_valid", wv1, 1);
    check("accept_word", word1, 0);
    ones = 0; sats = 0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      check("o1_word", word1, (n % 4 == 0) ? 11 : 10);
      if (word1 == 5'd11) ones++;
      if (sat1) sats++;
    end
    check("o1_ones", ones, 8);
    check("o1_sats", sats, 0);
    tick();
    tick();
    // Accept mid-run at acc1=16: phase must survive the load
    accept(20, 8);
    check("load_old_word", word1, 10);
    tick();
    check("load_phase_kept", word1, 21);
    tick();
    check("load_new_int", word1, 20);

    // en dropped 5 cycles after update 7 with tune_valid held high
    do_reset();
    accept(10, 8);
    for (int n = 1; n <= 7; n++) begin
      tick();
      check("hold_pre", word1, (n % 4 == 0) ? 11 : 10);
    end
    en = 1'b0; tune_valid = 1'b1; tune_word = {5'd3, 5'd0};
    #1;
    check("hold_ready_fall", rdy1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_word", word1, 10);
      check("hold_ready", rdy1, 0);
      check("hold_valid", wv1, 1);
    end
    en = 1'b1; tune_valid = 1'b0;
    tick();
    check("hold_exit_word", word1, 10);
    for (int n = 8; n <= 16; n++) begin
      tick();
      check("hold_resume", word1, (n % 4 == 0) ? 11 : 10);
    end

    // Reset mid-run, then replay from zeroed accumulators
    do_reset();
    accept(10, 8);
    for (int n = 1; n <= 7; n++) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_word", word1, 0);
    check("midrst_valid", wv1, 0);
    check("midrst_ready", rdy1, 0);
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    accept(10, 8);
    for (int n = 1; n <= 8; n++) begin
      tick();
      check("replay_word", word1, (n % 4 == 0) ? 11 : 10);
    end

    // int=25 frac=16: carry pushes raw to 26 on every even update
    do_reset();
    accept(25, 16);
    sats = 0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      check("top_word", word1, 25);
      check("top_sat", sat1, (n % 2 == 0) ? 1 : 0);
      if (sat1) sats++;
    end
    check("top_sat_count", sats, 16);

    // Integer part above MAX, then random sweep bounded by MAX
    do_reset();
    accept(31, 0);
    check("over_first", word1, 0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("over_word", word1, 25);
      check("over_sat", sat1, 1);
      check("over_word2", word2, 25);
    end
    bad = 0;
    tune_valid = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      tune_word = 10'($urandom);
      tick();
      if (word1 > 5'd25 || word2 > 5'd25) bad++;
    end
    tune_valid = 1'b0;
    check("sweep_bound", bad, 0);

    // MASH 1-1, int=0 frac=1: integer reference of both carry chains
    do_reset();
    accept(0, 1);
    s_prev = 0; c2_prev = 0; bad = 0;
    for (int n = 1; n <= 64; n++) begin
      s_now = s_prev + (n % 32);
      c1 = (n % 32 == 0) ? 1 : 0;
      c2 = s_now / 32 - s_prev / 32;
      raw = c1 + c2 - c2_prev;
      exp_w = (raw < 0) ? 0 : raw;
      exp_s = (raw < 0) ? 1 : 0;
      tick();
      check("mash_word", word2, exp_w);
      check("mash_sat", sat2, exp_s);
      if (word2 > 5'd2) bad++;
      s_prev = s_now;
      c2_prev = c2;
    end
    check("mash_range", bad, 0);

    // frac=0 gives a steady word in both orders
    do_reset();
    accept(7, 0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("zero_frac_o1", word1, 7);
      check("zero_frac_o2", word2, 7);
      check("zero_frac_sat", sat2, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dco_tune_sd.md
DCO_TUNE_SD -- requirements
Module: dco_tune_sd

Interface
REQ-001 Parameter MAX, default 25: largest legal output word, which is the number of unit cells in the 5x5 capacitor array.
REQ-002 Parameter FRAC_W, default 5: width of the fractional tuning field.
REQ-003 Parameter ORDER, default 1: dither order; legal values are 1 (first-order accumulator) or 2 (MASH 1-1).
REQ-004 clk  input  1: dither clock; all state updates on the posedge, so the downstream row/col coder samples on the following negedge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 en  input  1: dither enable; low freezes all state.
REQ-007 tune_valid  input  1: tuning word offered by the loop filter.
REQ-008 tune_word  input  5+FRAC_W: tuning word; bits [FRAC_W+4:FRAC_W] are the unsigned integer part, bits [FRAC_W-1:0] are the fraction.
REQ-009 tune_ready  output  1: block accepts tune_word this cycle.
REQ-010 word  output  5: dithered integer word to the row/col coder, range 0..MAX.
REQ-011 word_valid  output  1: word carries a dithered value, i.e. the block is not in IDLE.
REQ-012 sat  output  1: word was clamped on this update.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-014 The FSM SHALL leave reset in IDLE.
REQ-015 IDLE->RUN SHALL occur on the first accepted tuning word.
REQ-016 RUN->HOLD SHALL occur when en=0, and HOLD->RUN SHALL occur when en=1.
REQ-017 tune_ready SHALL be 1 in IDLE and RUN when en=1, and 0 in HOLD, when en=0, and during reset.
REQ-018 Accept SHALL occur on tune_valid&&tune_ready at a posedge; int_r and frac_r are then loaded from tune_word.
REQ-019 Accumulators SHALL NOT be cleared on accept; the dither phase continues across loads.
REQ-020 In RUN with en=1, every posedge SHALL update the accumulators from the current int_r and frac_r. An accept on that edge SHALL therefore take effect in word at the next edge (latency 1 cycle from accept to first use, 2 edges to output).
REQ-021 ORDER=1: acc1_nxt = acc1 + frac_r, modulo 2^FRAC_W; c1 = carry out; raw = int_r + c1.
REQ-022 ORDER=2: acc1 SHALL behave as in REQ-021. acc2_nxt = acc2 + acc1_nxt, modulo 2^FRAC_W; c2 = carry out; raw = int_r + c1 + c2 - c2_d, where c2_d is c2 from the previous update.
REQ-023 raw SHALL be computed signed at 7 bits, giving a range of -1..33.
REQ-024 raw SHALL be clamped as follows: raw<0 -> word=0, sat=1; raw>MAX -> word=MAX, sat=1; otherwise word=raw, sat=0.
REQ-025 word and sat SHALL be registered outputs, updated on the same edge as the accumulators.
REQ-026 An integer part greater than MAX SHALL be accepted without error; it produces word=MAX with sat=1 on every update.
REQ-027 In IDLE, word SHALL hold 0, sat SHALL be 0 and the accumulators SHALL NOT update.
REQ-028 In HOLD, word, sat, accumulators, c2_d, int_r and frac_r SHALL all hold their values; tune_valid is ignored.
REQ-029 A simultaneous accept and en fall is impossible because tune_ready=0 while en=0. If en falls at the same edge as a RUN update, that update SHALL NOT occur.
REQ-030 frac_r=0 SHALL produce word=clamp(int_r) with no toggling for both ORDER values, provided the accumulators are 0 or settled. For ORDER=2, the c2-c2_d term SHALL resolve to 0 within 2 updates.

Reset
REQ-031 Asserting rst SHALL immediately force state=IDLE, word=0, sat=0, word_valid=0, tune_ready=0, int_r=0, frac_r=0, acc1=0, acc2=0, c2_d=0.
REQ-032 After rst deasserts, tune_ready SHALL rise at the first posedge with en=1.
REQ-033 rst asserted mid-RUN SHALL abort the dither sequence; the first accept after reset SHALL restart from zeroed accumulators.

Verification
REQ-034 ORDER=1: accept int=10, frac=8, then 32 RUN cycles -> word=11 exactly 8 times and 10 for the other 24; sat never set; the 11s are evenly spaced, one every 4 cycles.
REQ-035 ORDER=1: accept int=25, frac=16 -> word=25 for all 32 cycles; sat=1 on exactly 16 of 32 cycles.
REQ-036 ORDER=2: accept int=0, frac=1, run 64 cycles -> word is never less than 0; every cycle with raw=-1 shows word=0 and sat=1; word stays within 0..2.
REQ-037 en dropped for 5 cycles mid-RUN with tune_valid held high -> tune_ready=0, word frozen, no accept; after en returns, the sequence resumes from the frozen accumulator values, matching a reference model with the 5 cycles removed.
REQ-038 rst pulsed at cycle 7 of scenario REQ-034 -> word=0 and word_valid=0 immediately; re-accepting int=10, frac=8 reproduces the scenario from cycle 0.
REQ-039 Accept int=31, frac=0 -> word=25 and sat=1 from the second edge onward; the output never exceeds MAX for any tune_word across a random sweep of 10k words.
